// File: rtl/jtmx5k_pcm_arb.sv
// Two-channel PCM ROM fetch arbiter: one-word cache per 007232 channel,
// misses serialised round-robin onto a single 16-bit memory slot.
module jtmx5k_pcm_arb #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [AW-1:0] a_addr,
  input  logic          a_cs,
  output logic [7:0]    a_dout,
  output logic          a_ok,
  input  logic [AW-1:0] b_addr,
  input  logic          b_cs,
  output logic [7:0]    b_dout,
  output logic          b_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_cs,
  input  logic          mem_ok,
  input  logic [15:0]   mem_data
);

  localparam int TW = AW - 1;

  typedef enum logic { IDLE, REQ } state_t;

  state_t        state, state_nx;
  logic          valid_a, valid_b;
  logic [TW-1:0] tag_a, tag_b;
  logic [15:0]   data_a, data_b;
  logic          last;
  logic          drop;
  logic          hit_a, hit_b, miss_a, miss_b;
  logic          pick, start, fill;

  assign hit_a  = a_cs & valid_a & (tag_a == a_addr[AW-1:1]);
  assign hit_b  = b_cs & valid_b & (tag_b == b_addr[AW-1:1]);
  assign miss_a = a_cs & ~hit_a;
  assign miss_b = b_cs & ~hit_b;

  assign a_ok   = hit_a;
  assign b_ok   = hit_b;
  assign a_dout = a_addr[0] ? data_a[15:8] : data_a[7:0];
  assign b_dout = b_addr[0] ? data_b[15:8] : data_b[7:0];

  // Contention goes to whichever channel was not filled last
  assign pick = (miss_a & miss_b) ? ~last : miss_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_cs   = 1'b0;
    start    = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE: begin
        if (miss_a | miss_b) begin
          start    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        mem_cs = 1'b1;
        if (mem_ok) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // mem_addr doubles as the latched channel select and tag for the fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
    end else if (start) begin
      mem_addr <= {pick, pick ? b_addr[AW-1:1] : a_addr[AW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      tag_a   <= '0;
      tag_b   <= '0;
      data_a  <= '0;
      data_b  <= '0;
      last    <= 1'b1;
      drop    <= 1'b0;
    end else begin
      if (fill && !mem_addr[AW-1]) begin
        tag_a   <= mem_addr[TW-1:0];
        data_a  <= mem_data;
        valid_a <= ~drop;
      end
      if (fill && mem_addr[AW-1]) begin
        tag_b   <= mem_addr[TW-1:0];
        data_b  <= mem_data;
        valid_b <= ~drop;
      end
      if (fill) last <= mem_addr[AW-1];
      // A flush on the fill edge still beats the fill
      if (flush) begin
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end
      if (fill)                        drop <= 1'b0;
      else if (flush && state == REQ)  drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtmx5k_pcm_arb.sv
// Self-checking bench for jtmx5k_pcm_arb: a latency-programmable memory model
// checks every fetch address against a queue of expected requests.
module tb_jtmx5k_pcm_arb;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_cs, b_cs;
  logic [7:0]    a_dout, b_dout;
  logic          a_ok, b_ok;
  logic [AW-1:0] mem_addr;
  logic          mem_cs;
  logic          mem_ok;
  logic [15:0]   mem_data;

  int total = 0;
  int bad   = 0;
  int memLat = 3;
  int ackCount = 0;
  int reqCount = 0;
  bit strayReq = 0;
  logic [31:0] expQ[$];

  jtmx5k_pcm_arb #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_addr(a_addr), .a_cs(a_cs), .a_dout(a_dout), .a_ok(a_ok),
    .b_addr(b_addr), .b_cs(b_cs), .b_dout(b_dout), .b_ok(b_ok),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_ok(mem_ok), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [AW-1:0] w);
    logic [7:0] lo;
    if (w == 17'h00008) return 16'hBEEF;
    lo = w[7:0] + w[15:8] * 8'd3 + (w[16] ? 8'h55 : 8'h3C);
    return {~w[7:0], lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: answers each request after memLat cycles, checking its address
  initial begin
    int cnt;
    bit prevCs;
    logic [31:0] e;
    cnt = 0;
    prevCs = 0;
    mem_ok = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_cs && !prevCs) reqCount++;
      prevCs = mem_cs;
      if (!rst_n) begin
        mem_ok = 1'b0;
        cnt = 0;
      end else if (mem_ok) begin
        mem_ok = 1'b0;
      end else if (strayReq) begin
        mem_ok = 1'b1;
        mem_data = 16'hDEAD;
        strayReq = 0;
      end else if (mem_cs) begin
        cnt++;
        if (cnt >= memLat) begin
          mem_ok = 1'b1;
          mem_data = memWord(mem_addr);
          cnt = 0;
          ackCount++;
          e = (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFF_FFFF;
          checkOutput("memaddr", {15'd0, mem_addr}, e);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic applyStimulus(input logic acs, input logic [AW-1:0] aad,
                               input logic bcs, input logic [AW-1:0] bad_addr);
    a_cs = acs;
    a_addr = aad;
    b_cs = bcs;
    b_addr = bad_addr;
    #1;
  endtask

  task automatic waitOk(input bit chB, input int budget, input string tag);
    int n;
    n = 0;
    while (!(chB ? b_ok : a_ok) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'd0, chB ? b_ok : a_ok}, 32'd1);
  endtask

  task automatic waitAck(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ackCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, (ackCount >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic doReset();
    a_cs = 0;
    b_cs = 0;
    flush = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acks, reqs;
    rst_n = 1'b0;
    flush = 0;
    a_cs = 0; b_cs = 0; a_addr = '0; b_addr = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst a_ok", {31'd0, a_ok}, 0);
    checkOutput("rst b_ok", {31'd0, b_ok}, 0);
    checkOutput("rst mem_cs", {31'd0, mem_cs}, 0);
    checkOutput("rst mem_addr", {15'd0, mem_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic miss, fill, then odd byte hits locally
    memLat = 3;
    expQ.push_back(32'h00008);
    applyStimulus(1, 17'h00010, 0, '0);
    checkOutput("t1 miss", {31'd0, a_ok}, 0);
    waitOk(0, 20, "t1 a_ok");
    checkOutput("t1 even", {24'd0, a_dout}, 32'hEF);
    reqs = reqCount;
    applyStimulus(1, 17'h00011, 0, '0);
    checkOutput("t1 odd ok", {31'd0, a_ok}, 1);
    checkOutput("t1 odd", {24'd0, a_dout}, 32'hBE);
    repeat (4) @(negedge clk);
    checkOutput("t1 no req", reqCount, reqs);

    // Contention from reset: A first; later, after a lone A fill, B first
    doReset();
    expQ.push_back(32'h00080);
    expQ.push_back(32'h10100);
    applyStimulus(1, 17'h00100, 1, 17'h00200);
    waitOk(0, 30, "t2 a_ok");
    waitOk(1, 30, "t2 b_ok");
    checkOutput("t2 a_dout", {24'd0, a_dout}, {24'd0, memWord(17'h00080) & 16'h00FF});
    checkOutput("t2 b_dout", {24'd0, b_dout}, {24'd0, memWord(17'h10100) & 16'h00FF});
    expQ.push_back(32'h00081);
    applyStimulus(1, 17'h00102, 1, 17'h00200);
    waitOk(0, 30, "t2 lone a");
    expQ.push_back(32'h10200);
    expQ.push_back(32'h00180);
    applyStimulus(1, 17'h00300, 1, 17'h00400);
    waitOk(1, 30, "t2 rr b_ok");
    waitOk(0, 30, "t2 rr a_ok");
    checkOutput("t2 rr b_dout", {24'd0, b_dout}, {24'd0, memWord(17'h10200) & 16'h00FF});
    checkOutput("t2 rr a_dout", {24'd0, a_dout}, {24'd0, memWord(17'h00180) & 16'h00FF});

    // Address change during a request: old fill lands, new one follows
    memLat = 6;
    expQ.push_back(32'h00010);
    expQ.push_back(32'h00020);
    applyStimulus(1, 17'h00020, 0, '0);
    acks = ackCount;
    repeat (2) @(negedge clk);
    applyStimulus(1, 17'h00040, 0, '0);
    waitAck(acks + 1, 20, "t3 old ack");
    @(negedge clk);
    checkOutput("t3 stale ok", {31'd0, a_ok}, 0);
    checkOutput("t3 idle gap", {31'd0, mem_cs}, 0);
    waitOk(0, 30, "t3 new ok");
    checkOutput("t3 a_dout", {24'd0, a_dout}, {24'd0, memWord(17'h00020) & 16'h00FF});

    // Flush on the fill edge wins
    memLat = 3;
    expQ.push_back(32'h00030);
    expQ.push_back(32'h00030);
    acks = ackCount;
    applyStimulus(1, 17'h00060, 0, '0);
    waitAck(acks + 1, 20, "t4 ack");
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    checkOutput("t4 flush edge", {31'd0, a_ok}, 0);
    waitOk(0, 30, "t4 refill");

    // Flush mid-request discards the fill
    memLat = 5;
    expQ.push_back(32'h00040);
    expQ.push_back(32'h00040);
    acks = ackCount;
    applyStimulus(1, 17'h00080, 0, '0);
    repeat (2) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    waitAck(acks + 1, 20, "t4b ack");
    @(negedge clk);
    checkOutput("t4b dropped", {31'd0, a_ok}, 0);
    waitOk(0, 30, "t4b refill");
    checkOutput("t4b a_dout", {24'd0, a_dout}, {24'd0, memWord(17'h00040) & 16'h00FF});

    // Reset in the middle of a request, then a stray ack
    memLat = 10;
    applyStimulus(1, 17'h000A0, 0, '0);
    repeat (3) @(negedge clk);
    checkOutput("t5 in req", {31'd0, mem_cs}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5 rst cs", {31'd0, mem_cs}, 0);
    checkOutput("t5 rst ok", {31'd0, a_ok}, 0);
    checkOutput("t5 rst addr", {15'd0, mem_addr}, 0);
    a_cs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strayReq = 1;
    repeat (4) @(negedge clk);
    memLat = 3;
    expQ.push_back(32'h00000);
    applyStimulus(1, 17'h00000, 0, '0);
    checkOutput("t5 stray", {31'd0, a_ok}, 0);
    waitOk(0, 30, "t5 fill");
    checkOutput("t5 a_dout", {24'd0, a_dout}, {24'd0, memWord(17'h00000) & 16'h00FF});

    // Deasserted chip select keeps the cache, no memory traffic
    expQ.push_back(32'h10111);
    applyStimulus(0, 17'h00000, 1, 17'h00222);
    waitOk(1, 30, "t6 fill");
    checkOutput("t6 b_dout", {24'd0, b_dout}, {24'd0, memWord(17'h10111) & 16'h00FF});
    reqs = reqCount;
    applyStimulus(0, 17'h00000, 0, 17'h00222);
    checkOutput("t6 cs low", {31'd0, b_ok}, 0);
    repeat (4) @(negedge clk);
    applyStimulus(0, 17'h00000, 1, 17'h00223);
    checkOutput("t6 reassert", {31'd0, b_ok}, 1);
    checkOutput("t6 odd", {24'd0, b_dout}, {24'd0, memWord(17'h10111) >> 8});
    repeat (4) @(negedge clk);
    checkOutput("t6 no req", reqCount, reqs);

    checkOutput("queue drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
